// File: rtl/mem_wb_stage_buffer_pkg.sv
// Shared MEM/WB pipeline definitions: default widths, writeback entry type
// and the architectural zero register index.
package mem_wb_stage_buffer_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;

  // Register $0 is hard-wired; results aimed at it are never forwarded.
  localparam logic [REG_ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

  // One buffered writeback result (data already MemtoReg-selected).
  typedef struct packed {
    logic [REG_ADDR_W_DEF-1:0] reg_idx;
    logic                      reg_write;
    logic [DATA_W_DEF-1:0]     data;
  } mem_wb_entry_t;

  // Writeback data selection applied when an entry is captured.
  function automatic logic [DATA_W_DEF-1:0] wb_select(
    input logic                  mem_to_reg,
    input logic [DATA_W_DEF-1:0] read_data,
    input logic [DATA_W_DEF-1:0] alu_result
  );
    logic [DATA_W_DEF-1:0] sel;
    if (mem_to_reg) begin
      sel = read_data;
    end else begin
      sel = alu_result;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mem_wb_stage_buffer_fifo_ctrl.sv
// Pointer/occupancy control for the MEM/WB in-order buffer. Flush wins over
// push and pop; push and pop in the same cycle keep the occupancy constant.
module stage_fifo_ctrl #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push_req,
  input  logic             pop_req,
  output logic             in_ready,
  output logic             out_valid,
  output logic             push,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr
);

  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic [CNT_BITS-1:0] count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                pop;

  // Advance a pointer, wrapping from the last slot back to slot 0.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) begin
      n = {PTR_W{1'b0}};
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  // Handshake qualifiers come only from registered occupancy.
  always_comb begin
    in_ready  = (count_q < CNT_BITS'(DEPTH));
    out_valid = (count_q != {CNT_BITS{1'b0}});
    push      = push_req & in_ready & ~flush;
    pop       = pop_req & out_valid & ~flush;
  end

  // Next pointers and occupancy from flush/push/pop arbitration.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = {CNT_BITS{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_d = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_BITS'(1);
        2'b01:   count_d = count_q - CNT_BITS'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register, updated on the falling edge.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= {CNT_BITS{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;

endmodule

// File: rtl/mem_wb_stage_buffer.sv
// MEM/WB stage buffer: DEPTH-entry in-order queue between the memory stage
// and register writeback, with a forwarding tap and saturating stall counter.
module mem_wb_stage_buffer
  import mem_wb_stage_buffer_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  hit,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     readData,
  input  logic [DATA_W-1:0]     ALUResult,
  input  logic [REG_ADDR_W-1:0] writeReg,
  input  logic                  RegWrite,
  input  logic                  MemtoReg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] writeRegOut,
  output logic                  RegWriteOut,
  output logic [DATA_W-1:0]     writeDataOut,
  output logic                  fwd_en,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REG_ADDR_W-1:0] reg_q  [DEPTH];
  logic                  rw_q   [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];

  logic                  push_s;
  logic [PTR_W-1:0]      wr_ptr_s;
  logic [PTR_W-1:0]      rd_ptr_s;
  logic                  valid_in_s;
  logic [DATA_W-1:0]     wdata_s;
  logic [CNT_W-1:0]      stall_q, stall_d;

  assign valid_in_s = in_valid & hit;

  stage_fifo_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ctrl (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .push_req  (valid_in_s),
    .pop_req   (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .push      (push_s),
    .wr_ptr    (wr_ptr_s),
    .rd_ptr    (rd_ptr_s)
  );

  // Select the writeback value when the entry is captured.
  always_comb begin
    if (MemtoReg) begin
      wdata_s = readData;
    end else begin
      wdata_s = ALUResult;
    end
  end

  // Entry storage: write the tail slot on an accepted push.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= {REG_ADDR_W{1'b0}};
        rw_q[i]   <= 1'b0;
        data_q[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      reg_q[wr_ptr_s]  <= writeReg;
      rw_q[wr_ptr_s]   <= RegWrite;
      data_q[wr_ptr_s] <= wdata_s;
    end
  end

  // Head presentation and forwarding tap; RegWrite is masked when empty.
  always_comb begin
    writeRegOut  = reg_q[rd_ptr_s];
    writeDataOut = data_q[rd_ptr_s];
    RegWriteOut  = out_valid & rw_q[rd_ptr_s];
    fwd_en       = RegWriteOut & (writeRegOut != REG_ADDR_W'(REG_ZERO));
    fwd_reg      = writeRegOut;
    fwd_data     = writeDataOut;
  end

  // Stall counter next value: count refused valid inputs, hold at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (valid_in_s && !in_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register; cleared only by reset.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= {CNT_W{1'b0}};
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: doc/mem_wb_stage_buffer.md
Name: mem_wb_stage_buffer

Overview:
- Parametrised MEM/WB pipeline stage sitting between the data-memory/cache stage and register-file writeback.
- Replaces a single hit-gated register with a DEPTH-entry in-order buffer. Adds valid/ready handshaking, flush, writeback-data selection, a forwarding tap and a saturating stall counter.
- The memory stage can complete while writeback is back-pressured, without losing or duplicating results.

Parameters:
- DATA_W, 32, width of readData/ALUResult/write data.
- REG_ADDR_W, 5, width of destination register index.
- DEPTH, 2, number of buffered entries (>=1; need not be a power of two).
- CNT_W, 16, width of stall-cycle counter.

Ports:
- clock  in  1  stage clock; all state updates on falling edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all buffered entries (synchronous).
- in_valid  in  1  memory stage presents a result.
- hit  in  1  cache hit; an input is only valid when in_valid & hit.
- in_ready  out  1  buffer can accept this cycle.
- readData  in  DATA_W  data loaded from memory.
- ALUResult  in  DATA_W  ALU result / address.
- writeReg  in  REG_ADDR_W  destination register.
- RegWrite  in  1  entry writes the register file.
- MemtoReg  in  1  1 selects readData, 0 selects ALUResult.
- out_valid  out  1  head entry present.
- out_ready  in  1  writeback consumes head.
- writeRegOut  out  REG_ADDR_W  head destination.
- RegWriteOut  out  1  head RegWrite, forced 0 when out_valid=0.
- writeDataOut  out  DATA_W  head write data (already MemtoReg-selected).
- fwd_en  out  1  out_valid & RegWriteOut & (writeRegOut != 0).
- fwd_reg  out  REG_ADDR_W  equals writeRegOut.
- fwd_data  out  DATA_W  equals writeDataOut.
- stall_cnt  out  CNT_W  falling edges where in_valid & hit & !in_ready; saturates at all-ones.

Behaviour:
- Reset (async, reset_n=0): count=0, rd/wr pointers=0, all storage=0, stall_cnt=0. Hence out_valid=0, in_ready=1, all data outputs 0. Release is synchronous to the next falling edge.
- Storage: circular array of DEPTH entries, each {writeReg, RegWrite, wdata}. wdata = MemtoReg ? readData : ALUResult, selected at push time.
- in_ready = (count < DEPTH), derived from registered state only; there is no combinational path from out_ready.
- push = in_valid & hit & in_ready. pop = out_valid & out_ready. out_valid = (count != 0).
- Each falling edge:
  - flush=1: count, pointers ← 0; push is ignored; stall_cnt unaffected.
  - push & !pop: write at wr_ptr, wr_ptr++ (wraps DEPTH-1 → 0), count++.
  - pop & !push: rd_ptr++ (wrap), count--.
  - push & pop: both pointers advance, count unchanged; legal at any count < DEPTH.
- Latency: an entry pushed at edge N is visible on outputs after edge N when the buffer was empty. Otherwise it appears after all older entries pop. Order is strictly FIFO.
- Outputs are driven from the head entry via rd_ptr. When out_valid=0, RegWriteOut=0 and fwd_en=0; writeRegOut and writeDataOut hold the stale head contents.
- in_valid & !hit: no push, no stall count. Entries with RegWrite=0 still occupy a slot and must be popped.
- writeReg=0 with RegWrite=1: the entry is buffered and presented normally, but fwd_en=0.
- stall_cnt increments by 1 per qualifying edge, holds at 2^CNT_W-1, and clears only on reset.

Decomposition:
- Shared pipeline package holds:
  - the mem_wb entry struct type {reg index, RegWrite, data};
  - default width constants DATA_W=32, REG_ADDR_W=5;
  - the register-zero constant.
- One natural sub-module: stage_fifo_ctrl, which owns pointers, count, wrap, in_ready/out_valid and push/pop/flush arbitration. The top instantiates it beside the entry array, write-data mux, forward logic and stall counter.

Test Plan:
- Reset mid-stream: fill 2 entries, pulse reset_n low between edges → out_valid=0, in_ready=1, stall_cnt=0 immediately, with no clock edge needed.
- Single pass: push {ALUResult=0x10, MemtoReg=0, writeReg=5, RegWrite=1}, out_ready=1 → after that edge writeDataOut=0x10, fwd_en=1, fwd_reg=5. Next edge, with no new push, out_valid=0.
- Back-pressure/full (DEPTH=2): out_ready=0, push readData 0xA, then 0xB, both MemtoReg=1 → in_ready=0. A third in_valid&hit for 3 edges → stall_cnt=3. Then raise out_ready → outputs 0xA then 0xB in order.
- Simultaneous push/pop with wrap: keep count=1 while streaming 6 entries with values 1..6 → outputs 1..6 with no gaps and in_ready=1 throughout.
- Flush priority: count=2 with flush=1 and a concurrent push → count=0 after the edge and the pushed entry is not observed.
- Hit gating and $0: in_valid=1, hit=0 → no push, stall_cnt unchanged. Push writeReg=0, RegWrite=1 → out_valid=1, RegWriteOut=1, fwd_en=0. Saturation: CNT_W=2, 5 stall edges → stall_cnt=3.
